alu_pipe: RTL

Parametrised, handshaked successor to the 8-bit combinational ALU for the RISC pipeline's execute stage. Operands and opcode enter through a valid/ready handshake. The result and a four-bit flag set leave through a registered valid/ready output port. The opcode set adds signed/unsigned compare, shifts, and an optional iterative multiply. Opcodes 0–6 keep the legacy 3-bit ALU encoding zero-extended, so the existing decoder drives the block unchanged.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_mul_seq.sv | 50 +++++
 rtl/alu_pipe.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types for the handshaked execute-stage ALU: opcodes, flag set, FSM states.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOT  = 4'd5,
    OP_SLT  = 4'd6,
    OP_SLTU = 4'd7,
    OP_SLL  = 4'd8,
    OP_SRL  = 4'd9,
    OP_SRA  = 4'd10,
    OP_MUL  = 4'd11
  } op_e;

  typedef struct packed {
    logic ovf;
    logic carry;
    logic neg;
    logic zero;
  } flags_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam flags_t FLAGS_RSVD = 4'b0001;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles after start.
module alu_mul_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done_c,
  output logic [2*WIDTH-1:0]   product_c
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               busy;

  // Product is taken from the adder output so the last step and the result capture share an edge.
  assign acc_nxt   = acc + (mplier[0] ? mcand : '0);
  assign done_c    = busy && (cnt == CW'(WIDTH - 1));
  assign product_c = acc_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      mcand  <= (2*WIDTH)'(a);
      acc    <= '0;
      mplier <= b;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      busy   <= !done_c;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked execute-stage ALU with registered result/flags.
// Define ALU_MUL_EN to enable the iterative multiply on opcode 11.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] HOLD = ST_HOLD;
`ifdef ALU_MUL_EN
  localparam logic [1:0] MULS = ST_MUL;
`endif

  logic [1:0]       rst_q;
  logic             rst_sync_n;
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] res_nxt;
  flags_t           flags_q;
  flags_t           flg_nxt;
  logic             vld_nxt;
  logic             accept;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] alu_res;
  flags_t           alu_flg;
  logic             rsvd;

`ifdef ALU_MUL_EN
  logic               mul_start_c;
  logic               mul_done_c;
  logic [2*WIDTH-1:0] mul_prod_c;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst_n     (rst_sync_n),
    .start     (mul_start_c),
    .a         (a),
    .b         (b),
    .done_c    (mul_done_c),
    .product_c (mul_prod_c)
  );
`endif

  assign flags = flags_q;

  // Reset: asserts immediately, releases two edges after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_q <= 2'b00;
    else        rst_q <= {rst_q[0], 1'b1};
  end
  assign rst_sync_n = rst_q[1];

  // Single-cycle operations; opcode 11 and 12-15 fall through as reserved here.
  always_comb begin
    sum     = {1'b0, a} + {1'b0, b};
    dif     = {1'b0, a} - {1'b0, b};
    sh      = b[SHW-1:0];
    alu_res = '0;
    alu_flg = '0;
    rsvd    = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res       = sum[WIDTH-1:0];
        alu_flg.carry = sum[WIDTH];
        alu_flg.ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res       = dif[WIDTH-1:0];
        alu_flg.carry = dif[WIDTH];
        alu_flg.ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOT:  alu_res = ~a;
      OP_SLT:  alu_res = WIDTH'($signed(a) < $signed(b));
      OP_SLTU: alu_res = WIDTH'(a < b);
      OP_SLL:  alu_res = a << sh;
      OP_SRL:  alu_res = a >> sh;
      OP_SRA:  alu_res = $signed(a) >>> sh;
      default: rsvd = 1'b1;
    endcase
    alu_flg.neg  = alu_res[WIDTH-1];
    alu_flg.zero = (alu_res == '0);
    if (rsvd) alu_flg = FLAGS_RSVD;
  end

  // Next-state, handshake and result capture.
  always_comb begin
    state_nxt = state;
    res_nxt   = result;
    flg_nxt   = flags_q;
    vld_nxt   = out_valid;
`ifdef ALU_MUL_EN
    mul_start_c = 1'b0;
`endif
    case (state)
      IDLE:    in_ready = 1'b1;
      HOLD:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
    in_ready = in_ready & rst_sync_n;
    accept   = in_valid & in_ready;

    if (accept) begin
`ifdef ALU_MUL_EN
      if (op == OP_MUL) begin
        mul_start_c = 1'b1;
        vld_nxt     = 1'b0;
        state_nxt   = MULS;
      end else begin
`else
      begin
`endif
        res_nxt   = alu_res;
        flg_nxt   = alu_flg;
        vld_nxt   = 1'b1;
        state_nxt = HOLD;
      end
    end else if (state == HOLD) begin
      if (out_ready) begin
        vld_nxt   = 1'b0;
        state_nxt = IDLE;
      end
`ifdef ALU_MUL_EN
    end else if (state == MULS) begin
      if (mul_done_c) begin
        res_nxt       = mul_prod_c[WIDTH-1:0];
        flg_nxt.ovf   = 1'b0;
        flg_nxt.carry = |mul_prod_c[2*WIDTH-1:WIDTH];
        flg_nxt.neg   = mul_prod_c[WIDTH-1];
        flg_nxt.zero  = (mul_prod_c[WIDTH-1:0] == '0);
        vld_nxt       = 1'b1;
        state_nxt     = HOLD;
      end
`endif
    end else if (state != IDLE) begin
      vld_nxt   = 1'b0;
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state     <= IDLE;
      result    <= '0;
      flags_q   <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      result    <= res_nxt;
      flags_q   <= flg_nxt;
      out_valid <= vld_nxt;
    end
  end

endmodule
